// File: rtl/soc_cmd_sequencer.sv
// Two-byte command sequencer for the CI harness: SoC clock gate, reset pulse, UART routing.
// Optional argument-byte timeout is enabled by defining SOC_CMD_TIMEOUT_EN.
module soc_cmd_sequencer #(
  parameter int PULSE_UNIT     = 1000,
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       soc_clk_en,
  output logic       soc_reset,
  output logic       tx_route,
  output logic       rx_block,
  output logic       led_n
);

  typedef enum logic [1:0] {
    IDLE,
    GET_ARG,
    EXEC,
    SEND
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;
  localparam logic [7:0] TMO = 8'hEE;

  state_t state, state_nx;

  logic [7:0]       opcode;
  logic [7:0]       arg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             timed;
  logic             tx_sel;
  logic             overrun;
  logic             own_tx;
  logic             timeout;

  assign load_val = CNT_W'(arg) * CNT_W'(PULSE_UNIT);

`ifdef SOC_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      tcnt <= '0;
    else if (state != GET_ARG)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // A byte arriving on the expiry cycle still counts as the argument.
  assign timeout = (state == GET_ARG) && !rx_valid &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid)
          state_nx = GET_ARG;
      end
      GET_ARG: begin
        if (rx_valid)
          state_nx = EXEC;
        else if (timeout)
          state_nx = SEND;
      end
      EXEC: begin
        state_nx = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_en    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opcode <= '0;
      arg    <= '0;
    end else begin
      if (state == IDLE && rx_valid)
        opcode <= rx_data;
      if (state == GET_ARG && rx_valid)
        arg <= rx_data;
    end
  end

  // own_tx keeps the wire on the controller until our byte has left.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      own_tx <= 1'b0;
    else if (tx_en)
      own_tx <= 1'b1;
    else if (!tx_busy)
      own_tx <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data    <= '0;
      soc_clk_en <= 1'b1;
      soc_reset  <= 1'b0;
      tx_sel     <= 1'b0;
      rx_block   <= 1'b0;
      overrun    <= 1'b0;
      cnt        <= '0;
      timed      <= 1'b0;
    end else begin
      if (timed && cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          soc_reset <= 1'b0;
          timed     <= 1'b0;
        end
      end
      if (timeout)
        tx_data <= TMO;
      if (state == EXEC) begin
        tx_data <= ACK;
        case (opcode)
          8'h10: soc_clk_en <= arg[0];
          8'h20: begin
            soc_reset <= 1'b1;
            cnt       <= load_val;
            timed     <= (arg != 8'h00);
          end
          8'h21: begin
            soc_reset <= 1'b0;
            cnt       <= '0;
            timed     <= 1'b0;
          end
          8'h30: tx_sel <= arg[0];
          8'h31: rx_block <= arg[0];
          8'h40: begin
            tx_data <= {soc_reset, soc_clk_en, tx_sel,
                        rx_block, overrun, 3'b000};
            overrun <= 1'b0;
          end
          default: tx_data <= NAK;
        endcase
      end
      // A byte dropped on a STATUS cycle is a fresh overrun.
      if ((state == EXEC || state == SEND) && rx_valid)
        overrun <= 1'b1;
    end
  end

  assign tx_route = tx_sel | (state == SEND) | (own_tx & tx_busy);
  assign led_n    = ~soc_reset;

endmodule

// File: tb/tb_soc_cmd_sequencer.sv
// Directed bench for soc_cmd_sequencer with PULSE_UNIT=4.
// Define SOC_CMD_TIMEOUT_EN to also exercise the argument timeout (100 cycles).
module tb_soc_cmd_sequencer;

  logic       clk;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       soc_clk_en;
  logic       soc_reset;
  logic       tx_route;
  logic       rx_block;
  logic       led_n;

  int n_assert = 0;
  int n_fail   = 0;
  int hi_cnt   = 0;

  soc_cmd_sequencer #(
    .PULSE_UNIT(4),
    .CNT_W(20),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_busy(tx_busy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .soc_clk_en(soc_clk_en),
    .soc_reset(soc_reset),
    .tx_route(tx_route),
    .rx_block(rx_block),
    .led_n(led_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (soc_reset)
      hi_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] op,
                       input logic [7:0] a,
                       input logic [7:0] resp);
    send_byte(op);
    send_byte(a);
    tick();
    check("frame_tx_en", 32'(tx_en), 32'd1);
    check("frame_resp", 32'(tx_data), 32'(resp));
    tick();
    check("frame_tx_en_low", 32'(tx_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    #12;
    check("rst_clk_en", 32'(soc_clk_en), 32'd1);
    check("rst_reset", 32'(soc_reset), 32'd0);
    check("rst_route", 32'(tx_route), 32'd0);
    check("rst_rx_block", 32'(rx_block), 32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_led_n", 32'(led_n), 32'd1);
    tick();
    resetn = 1'b1;
    tick();

    // clock gate off, visible from the SEND cycle
    send_byte(8'h10);
    send_byte(8'h00);
    check("clk_en_in_exec", 32'(soc_clk_en), 32'd1);
    tick();
    check("clk_en_off", 32'(soc_clk_en), 32'd0);
    check("clk_tx_en", 32'(tx_en), 32'd1);
    check("clk_ack", 32'(tx_data), 32'hA5);
    check("send_route", 32'(tx_route), 32'd1);
    tick();
    check("clk_tx_en_once", 32'(tx_en), 32'd0);
    check("idle_route", 32'(tx_route), 32'd0);
    frame(8'h10, 8'h01, 8'hA5);
    check("clk_en_on", 32'(soc_clk_en), 32'd1);

    // timed pulse: 3 * 4 = 12 cycles
    hi_cnt = 0;
    frame(8'h20, 8'h03, 8'hA5);
    check("pulse_led_n", 32'(led_n), 32'd0);
    repeat (30) tick();
    check("pulse_len", 32'(hi_cnt), 32'd12);
    check("pulse_done", 32'(soc_reset), 32'd0);

    // reload 6 cycles into the pulse: 6 + 12 = 18
    hi_cnt = 0;
    send_byte(8'h20);
    send_byte(8'h03);
    tick();
    check("reload1_tx_en", 32'(tx_en), 32'd1);
    tick();
    tick();
    tick();
    send_byte(8'h20);
    send_byte(8'h03);
    tick();
    check("reload2_tx_en", 32'(tx_en), 32'd1);
    check("reload2_ack", 32'(tx_data), 32'hA5);
    repeat (11) tick();
    check("reload_last_hi", 32'(soc_reset), 32'd1);
    tick();
    check("reload_fall", 32'(soc_reset), 32'd0);
    check("reload_len", 32'(hi_cnt), 32'd18);

    // held reset until release
    frame(8'h20, 8'h00, 8'hA5);
    repeat (1000) tick();
    check("hold_reset", 32'(soc_reset), 32'd1);
    frame(8'h21, 8'h00, 8'hA5);
    check("release", 32'(soc_reset), 32'd0);
    check("release_led", 32'(led_n), 32'd1);

    // STATUS under tx_busy with a dropped byte in SEND
    tx_busy = 1'b1;
    send_byte(8'h40);
    send_byte(8'h00);
    tick();
    check("busy_wait0", 32'(tx_en), 32'd0);
    send_byte(8'h55);
    tick();
    tick();
    check("busy_wait1", 32'(tx_en), 32'd0);
    check("busy_route", 32'(tx_route), 32'd1);
    tx_busy = 1'b0;
    #1;
    check("busy_release_tx_en", 32'(tx_en), 32'd1);
    check("status_clean", 32'(tx_data), 32'h40);
    tick();
    check("status_idle", 32'(tx_en), 32'd0);
    frame(8'h40, 8'h00, 8'h48);
    frame(8'h40, 8'h00, 8'h40);

    // unknown opcode
    frame(8'h99, 8'h00, 8'h5A);
    check("nak_clk_en", 32'(soc_clk_en), 32'd1);
    check("nak_reset", 32'(soc_reset), 32'd0);
    check("nak_rx_block", 32'(rx_block), 32'd0);
    check("nak_route", 32'(tx_route), 32'd0);

    // routing selects
    frame(8'h30, 8'h01, 8'hA5);
    check("tx_sel_on", 32'(tx_route), 32'd1);
    frame(8'h31, 8'h01, 8'hA5);
    check("rx_block_on", 32'(rx_block), 32'd1);
    frame(8'h40, 8'h00, 8'h70);
    frame(8'h30, 8'h00, 8'hA5);
    frame(8'h31, 8'h00, 8'hA5);
    check("tx_sel_off", 32'(tx_route), 32'd0);
    check("rx_block_off", 32'(rx_block), 32'd0);

    // async reset mid-pulse and mid-frame
    frame(8'h10, 8'h00, 8'hA5);
    frame(8'h20, 8'h05, 8'hA5);
    tick();
    send_byte(8'h10);
    resetn = 1'b0;
    #2;
    check("arst_reset", 32'(soc_reset), 32'd0);
    check("arst_led_n", 32'(led_n), 32'd1);
    check("arst_clk_en", 32'(soc_clk_en), 32'd1);
    tick();
    resetn = 1'b1;
    tick();
    frame(8'h31, 8'h01, 8'hA5);
    check("arst_new_frame", 32'(rx_block), 32'd1);
    repeat (30) tick();
    check("arst_no_pulse", 32'(soc_reset), 32'd0);
    frame(8'h31, 8'h00, 8'hA5);

`ifdef SOC_CMD_TIMEOUT_EN
    send_byte(8'h30);
    repeat (99) tick();
    check("tmo_not_yet", 32'(tx_en), 32'd0);
    tick();
    check("tmo_tx_en", 32'(tx_en), 32'd1);
    check("tmo_resp", 32'(tx_data), 32'hEE);
    tick();
    check("tmo_route", 32'(tx_route), 32'd0);
    frame(8'h40, 8'h00, 8'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
